// File: rtl/shared_bus_arbiter_if.sv
// Bundles the request, release and enable signals between the bus masters and the arbiter.
interface shared_bus_arbiter_if #(
   parameter int unsigned N = 4
);
   logic [N-1:0] req;
   logic [N-1:0] done;
   logic [N-1:0] grant;
   logic [N-1:0] drive_en;
   logic         bus_busy;
   logic         timeout;

   modport master (
      output req, done,
      input  grant, drive_en, bus_busy, timeout
   );

   modport slave (
      input  req, done,
      output grant, drive_en, bus_busy, timeout
   );
endinterface

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter for the shared tristate bus: one-hot registered drive enables
// with a turnaround cycle before and after every tenure.
module shared_bus_arbiter #(
   parameter int unsigned N        = 4,
   parameter int unsigned HOLD_MAX = 8
) (
   input logic                  clk,
   input logic                  rst,
   shared_bus_arbiter_if.slave  bus
);

   localparam int unsigned OW = $clog2(N);
   localparam int unsigned CW = $clog2(HOLD_MAX + 1);

   typedef enum logic [1:0] {IDLE, GRANT, OWN, RELEASE} state_t;

   state_t          state, state_nxt;
   logic [OW-1:0]   owner, owner_nxt;
   logic [OW-1:0]   ptr, ptr_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [OW-1:0]   win, idx;
   logic            found;
   logic            at_limit;
   logic            timeout_nxt;
   logic [N-1:0]    owner_oh;
   logic [N-1:0]    grant_nxt, drive_en_nxt;
   logic            busy_nxt;

   // State and output registers; outputs are decoded from next state so they line up with it
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         owner        <= '0;
         ptr          <= '0;
         cnt          <= '0;
         bus.grant    <= '0;
         bus.drive_en <= '0;
         bus.bus_busy <= 1'b0;
         bus.timeout  <= 1'b0;
      end else begin
         state        <= state_nxt;
         owner        <= owner_nxt;
         ptr          <= ptr_nxt;
         cnt          <= cnt_nxt;
         bus.grant    <= grant_nxt;
         bus.drive_en <= drive_en_nxt;
         bus.bus_busy <= busy_nxt;
         bus.timeout  <= timeout_nxt;
      end
   end

   // Next-state, winner selection and output decode
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      ptr_nxt     = ptr;
      cnt_nxt     = cnt;
      timeout_nxt = 1'b0;
      found       = 1'b0;
      win         = owner;
      idx         = '0;
      at_limit    = (cnt == CW'(HOLD_MAX));

      unique case (state)
         IDLE: begin
            if (|bus.req) begin
               // Scan starting at ptr, wrapping mod N; first set bit wins
               for (int unsigned i = 0; i < N; i++) begin
                  idx = OW'((32'(ptr) + i) % N);
                  if (!found && bus.req[idx]) begin
                     found = 1'b1;
                     win   = idx;
                  end
               end
               owner_nxt = win;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (bus.req[owner]) begin
               state_nxt = OWN;
               cnt_nxt   = CW'(1);
            end else begin
               state_nxt = IDLE;
            end
         end
         OWN: begin
            if (bus.done[owner] || !bus.req[owner] || at_limit) begin
               state_nxt   = RELEASE;
               timeout_nxt = at_limit && !bus.done[owner] && bus.req[owner];
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         RELEASE: begin
            ptr_nxt   = (owner == OW'(N - 1)) ? '0 : owner + OW'(1);
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      owner_oh     = N'(1) << owner_nxt;
      grant_nxt    = (state_nxt == GRANT || state_nxt == OWN) ? owner_oh : '0;
      drive_en_nxt = (state_nxt == OWN) ? owner_oh : '0;
      busy_nxt     = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Self-checking bench for shared_bus_arbiter (N=4, HOLD_MAX=8): per-cycle vector table
// with expected outputs queued at drive time and compared after the sampling edge.
module tb_shared_bus_arbiter;

   localparam int unsigned N = 4;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] done;
      logic [3:0] grant;
      logic [3:0] drive_en;
      logic       busy;
      logic       timeout;
   } vec_t;

   typedef struct {
      logic [3:0] grant;
      logic [3:0] drive_en;
      logic       busy;
      logic       timeout;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];
   exp_t sb[$];

   shared_bus_arbiter_if #(.N(N)) bus ();

   shared_bus_arbiter #(.N(N), .HOLD_MAX(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic void add(logic r, logic [3:0] rq, logic [3:0] dn, logic [3:0] g,
                               logic [3:0] de, logic b, logic t);
      vec_t v;
      v.rst = r; v.req = rq; v.done = dn; v.grant = g; v.drive_en = de; v.busy = b; v.timeout = t;
      vecs.push_back(v);
   endfunction

   task automatic check(string name, int step, logic [3:0] act, logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
      end
   endtask

   initial begin
      logic [3:0] oh;
      exp_t       e;
      bus.req  = '0;
      bus.done = '0;

      // Reset
      add(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
      add(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);

      // Fairness: req=1111, done on first OWN cycle; order 0,1,2,3,0,1
      for (int k = 0; k < 6; k++) begin
         oh = 4'(1 << (k % 4));
         add(0, 4'hf, 4'h0, oh, 4'h0, 1, 0);
         add(0, 4'hf, (k == 0) ? 4'hf : 4'h0, oh, 4'h0 | oh, 1, 0);
         add(0, 4'hf, oh, 4'h0, 4'h0, 1, 0);
         add(0, 4'hf, 4'h0, 4'h0, 4'h0, 0, 0);
      end

      // Single request to master 2, done after four OWN cycles
      add(0, 4'h4, 4'h0, 4'h4, 4'h0, 1, 0);
      for (int k = 0; k < 4; k++) add(0, 4'h4, 4'h0, 4'h4, 4'h4, 1, 0);
      add(0, 4'h4, 4'h4, 4'h0, 4'h0, 1, 0);
      add(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);

      // Timeout: master 1 holds for exactly 8 OWN cycles, then is re-granted
      add(0, 4'h2, 4'h0, 4'h2, 4'h0, 1, 0);
      for (int k = 0; k < 8; k++) add(0, 4'h2, 4'h0, 4'h2, 4'h2, 1, 0);
      add(0, 4'h2, 4'h0, 4'h0, 4'h0, 1, 1);
      add(0, 4'h2, 4'h0, 4'h0, 4'h0, 0, 0);
      add(0, 4'h2, 4'h0, 4'h2, 4'h0, 1, 0);
      // Coincidence: non-owner done ignored, owner done on the 8th OWN cycle
      for (int k = 0; k < 8; k++) add(0, 4'h2, (k == 2) ? 4'hd : 4'h0, 4'h2, 4'h2, 1, 0);
      add(0, 4'h2, 4'h2, 4'h0, 4'h0, 1, 0);
      add(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);

      // Master 0 tenure with done[3] ignored; leaves ptr at 1
      add(0, 4'h1, 4'h0, 4'h1, 4'h0, 1, 0);
      add(0, 4'h1, 4'h0, 4'h1, 4'h1, 1, 0);
      add(0, 4'h1, 4'h8, 4'h1, 4'h1, 1, 0);
      add(0, 4'h1, 4'h1, 4'h0, 4'h0, 1, 0);
      add(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);

      // Abort in GRANT; master 1 keeps first priority
      add(0, 4'h2, 4'h0, 4'h2, 4'h0, 1, 0);
      add(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);
      add(0, 4'hf, 4'h0, 4'h2, 4'h0, 1, 0);
      add(0, 4'hf, 4'h0, 4'h2, 4'h2, 1, 0);
      add(0, 4'hf, 4'h2, 4'h0, 4'h0, 1, 0);
      add(0, 4'hf, 4'h0, 4'h0, 4'h0, 0, 0);

      // Reset during OWN of master 2, then grant restarts at master 0
      add(0, 4'hf, 4'h0, 4'h4, 4'h0, 1, 0);
      add(0, 4'hf, 4'h0, 4'h4, 4'h4, 1, 0);
      add(0, 4'hf, 4'h0, 4'h4, 4'h4, 1, 0);
      add(1, 4'hf, 4'h0, 4'h0, 4'h0, 0, 0);
      add(0, 4'hf, 4'h0, 4'h1, 4'h0, 1, 0);
      add(0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0);

      foreach (vecs[i]) begin
         rst      = vecs[i].rst;
         bus.req  = vecs[i].req;
         bus.done = vecs[i].done;
         e.grant    = vecs[i].grant;
         e.drive_en = vecs[i].drive_en;
         e.busy     = vecs[i].busy;
         e.timeout  = vecs[i].timeout;
         sb.push_back(e);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         check("grant",    i, bus.grant,    e.grant);
         check("drive_en", i, bus.drive_en, e.drive_en);
         check("bus_busy", i, {3'b0, bus.bus_busy}, {3'b0, e.busy});
         check("timeout",  i, {3'b0, bus.timeout},  {3'b0, e.timeout});
         check("drive_en_onehot", i, {3'b0, ($countones(bus.drive_en) <= 1)}, 4'h1);
         check("drive_en_implies_grant", i, bus.drive_en & ~bus.grant, 4'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
